phase_rx_collector: RTL and testbench

//  Collects one phase's module-data frames from the link deserializer into a ping-pong buffer.

---
 rtl/phase_rx_collector_pkg.sv | 27 ++
 rtl/phase_rx_bank_ram.sv | 27 ++
 rtl/phase_rx_collector.sv | 198 +++++++++++++++++++
 tb/tb_phase_rx_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/phase_rx_collector_pkg.sv
// Shared definitions for the per-phase receive collector.
//  - Writer FSM state encoding.
//  - Bank RAM geometry: each bank holds 128 words; address 0 is reserved
//    and never carries frame data, so data words occupy 1..NUM_WORDS.
//  - Checksum convention: 16-bit wrap-around sum of the data words, complemented.
package phase_rx_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2,
    ST_HOLD = 2'd3
  } wr_state_t;

  localparam int BANK_AW       = 7;
  localparam int ADDR_RESERVED = 0;

  function automatic logic [15:0] csum_of(input logic [15:0] sum);
    return ~sum;
  endfunction

  // True when a reader address selects a data word (never the reserved slot).
  function automatic logic addr_is_data(input logic [9:0] addr, input int num_words);
    return (addr != 10'(ADDR_RESERVED)) && (int'(addr) <= num_words);
  endfunction

endpackage

// File: rtl/phase_rx_bank_ram.sv
// Two-bank frame store, 256x16 simple dual-port RAM addressed {bank, addr[6:0]}.
// Ports:
//  clk_100M  system clock
//  we        write enable
//  waddr     write address {bank, word}
//  wdata     write data
//  raddr     read address {bank, word}
//  rdata     read data, registered (1-cycle latency)
module phase_rx_bank_ram
  import phase_rx_collector_pkg::*;
(
  input  logic               clk_100M,
  input  logic               we,
  input  logic [BANK_AW:0]   waddr,
  input  logic [15:0]        wdata,
  input  logic [BANK_AW:0]   raddr,
  output logic [15:0]        rdata
);

  logic [15:0] mem [0:(2**(BANK_AW+1))-1];

  always_ff @(posedge clk_100M) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/phase_rx_collector.sv
// Collects one phase's module-data frames into a ping-pong buffer and presents
// a stable, checksum-verified bank to the DPRAM writer.
// Ports:
//  clk_100M     system clock
//  reset_n      synchronous active-low reset
//  start_DPRAM  reader request; rising edge opens a read window of READ_WIN cycles
//  rx_valid     rx_data valid this cycle
//  rx_sof       with rx_valid: word is data word 1 of a frame
//  rx_data      received word
//  ram_addr     reader address (1..NUM_WORDS are data)
//  ram_data     read data, 1-cycle latency, 0 for out-of-range or invalid bank
//  bank_sel     bank currently presented to the reader
//  good_cnt     good frames accepted
//  fmt_err_cnt  checksum/format errors
//  ovr_cnt      frames dropped while a swap was pending
//  link_ok      a good frame was seen within TIMEOUT cycles
module phase_rx_collector
  import phase_rx_collector_pkg::*;
#(
  parameter int          NUM_WORDS = 78,
  parameter logic [9:0]  READ_WIN  = 10'd400,
  parameter logic [16:0] TIMEOUT   = 17'd100000
) (
  input  logic        clk_100M,
  input  logic        reset_n,
  input  logic        start_DPRAM,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic [15:0] rx_data,
  input  logic [9:0]  ram_addr,
  output logic [15:0] ram_data,
  output logic        bank_sel,
  output logic [15:0] good_cnt,
  output logic [15:0] fmt_err_cnt,
  output logic [15:0] ovr_cnt,
  output logic        link_ok
);

  localparam logic [BANK_AW-1:0] FIRST_IDX  = BANK_AW'(ADDR_RESERVED + 1);
  localparam logic [BANK_AW-1:0] SECOND_IDX = BANK_AW'(ADDR_RESERVED + 2);
  localparam logic [BANK_AW-1:0] LAST_IDX   = BANK_AW'(NUM_WORDS);

  logic               start_q;
  logic               snap;
  logic               busy;
  logic [9:0]         win_cnt;
  wr_state_t          state;
  logic [BANK_AW-1:0] idx;
  logic [15:0]        sum;
  logic               wr_bank;
  logic               rd_bank;
  logic [1:0]         bank_valid;
  logic [16:0]        to_cnt;
  logic               csum_good;
  logic               good_frame;
  logic               we;
  logic [BANK_AW-1:0] waddr;
  logic [15:0]        rd_word_p1;
  logic               rd_vld_p1;

  // start_q resets high so a start_DPRAM held high through reset is not an edge.
  assign snap       = start_DPRAM & ~start_q;
  assign busy       = (win_cnt != 10'd0) | snap;
  assign bank_sel   = rd_bank;
  assign csum_good  = rx_valid && !rx_sof && (rx_data == csum_of(sum));
  assign good_frame = (state == ST_CSUM) && csum_good;

  // Write decode: a sof word always lands at the first data slot.
  always_comb begin
    we    = 1'b0;
    waddr = FIRST_IDX;
    if (reset_n && rx_valid) begin
      case (state)
        ST_IDLE: we = rx_sof;
        ST_DATA: begin
          we    = 1'b1;
          waddr = rx_sof ? FIRST_IDX : idx;
        end
        ST_CSUM: we = rx_sof;
        default: we = 1'b0;
      endcase
    end
  end

  phase_rx_bank_ram u_ram (
    .clk_100M (clk_100M),
    .we       (we),
    .waddr    ({wr_bank, waddr}),
    .wdata    (rx_data),
    .raddr    ({rd_bank, ram_addr[BANK_AW-1:0]}),
    .rdata    (rd_word_p1)
  );

  // ---- read stage p1: mask qualifier travels with the RAM output register
  always_ff @(posedge clk_100M) begin
    if (!reset_n) rd_vld_p1 <= 1'b0;
    else          rd_vld_p1 <= addr_is_data(ram_addr, NUM_WORDS) && bank_valid[rd_bank];
  end

  assign ram_data = rd_vld_p1 ? rd_word_p1 : 16'd0;

  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      start_q <= 1'b1;
      win_cnt <= 10'd0;
    end else begin
      start_q <= start_DPRAM;
      if (snap)                 win_cnt <= READ_WIN;
      else if (win_cnt != 10'd0) win_cnt <= win_cnt - 10'd1;
    end
  end

  // Writer FSM. Swapping banks exchanges wr/rd so the reader's bank is never written.
  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= SECOND_IDX;
      wr_bank     <= 1'b1;
      rd_bank     <= 1'b0;
      bank_valid  <= 2'b00;
      good_cnt    <= 16'd0;
      fmt_err_cnt <= 16'd0;
      ovr_cnt     <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_sof) begin
            sum   <= rx_data;
            idx   <= SECOND_IDX;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            if (rx_sof) begin
              fmt_err_cnt <= fmt_err_cnt + 16'd1;
              sum         <= rx_data;
              idx         <= SECOND_IDX;
            end else begin
              sum <= sum + rx_data;
              if (idx == LAST_IDX) state <= ST_CSUM;
              else                 idx   <= idx + 7'd1;
            end
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            if (csum_good) begin
              good_cnt            <= good_cnt + 16'd1;
              bank_valid[wr_bank] <= 1'b1;
              if (!busy) begin
                rd_bank <= wr_bank;
                wr_bank <= rd_bank;
                state   <= ST_IDLE;
              end else begin
                state <= ST_HOLD;
              end
            end else begin
              fmt_err_cnt         <= fmt_err_cnt + 16'd1;
              bank_valid[wr_bank] <= 1'b0;
              if (rx_sof) begin
                sum   <= rx_data;
                idx   <= SECOND_IDX;
                state <= ST_DATA;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (rx_valid && rx_sof) ovr_cnt <= ovr_cnt + 16'd1;
          if (!busy) begin
            rd_bank <= wr_bank;
            wr_bank <= rd_bank;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Link watchdog: saturating count since the last good frame.
  always_ff @(posedge clk_100M) begin
    if (!reset_n) begin
      to_cnt  <= 17'd0;
      link_ok <= 1'b0;
    end else if (good_frame) begin
      to_cnt  <= 17'd0;
      link_ok <= 1'b1;
    end else if (to_cnt != TIMEOUT) begin
      to_cnt <= to_cnt + 17'd1;
      if (to_cnt == TIMEOUT - 17'd1) link_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_rx_collector.sv
module tb_phase_rx_collector;

  localparam int          NW = 78;
  localparam logic [16:0] TO = 17'd3000;

  logic        clk_100M = 1'b0;
  logic        reset_n;
  logic        start_DPRAM;
  logic        rx_valid;
  logic        rx_sof;
  logic [15:0] rx_data;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic        bank_sel;
  logic [15:0] good_cnt;
  logic [15:0] fmt_err_cnt;
  logic [15:0] ovr_cnt;
  logic        link_ok;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk_100M = ~clk_100M;

  phase_rx_collector #(
    .NUM_WORDS (NW),
    .READ_WIN  (10'd400),
    .TIMEOUT   (TO)
  ) dut (
    .clk_100M    (clk_100M),
    .reset_n     (reset_n),
    .start_DPRAM (start_DPRAM),
    .rx_valid    (rx_valid),
    .rx_sof      (rx_sof),
    .rx_data     (rx_data),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .bank_sel    (bank_sel),
    .good_cnt    (good_cnt),
    .fmt_err_cnt (fmt_err_cnt),
    .ovr_cnt     (ovr_cnt),
    .link_ok     (link_ok)
  );

  task automatic tick();
    @(posedge clk_100M);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic sof, input logic [15:0] d);
    rx_valid = 1'b1;
    rx_sof   = sof;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_data  = 16'd0;
  endtask

  // Data words are base+1 .. base+NW; checksum is ~sum or 0 for a bad frame.
  task automatic frame(input int base, input logic good);
    logic [15:0] s;
    s = 16'd0;
    for (int i = 1; i <= NW; i++) begin
      word(i == 1, 16'(base + i));
      s = s + 16'(base + i);
    end
    word(1'b0, good ? ~s : 16'h0000);
  endtask

  task automatic rd(input logic [9:0] a, output logic [15:0] d);
    ram_addr = a;
    tick();
    d = ram_data;
  endtask

  logic [15:0] d;
  int          e0;
  int          g;

  initial begin
    reset_n     = 1'b0;
    start_DPRAM = 1'b0;
    rx_valid    = 1'b0;
    rx_sof      = 1'b0;
    rx_data     = 16'd0;
    ram_addr    = 10'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("rst_good", good_cnt, 16'd0);
    check("rst_fmt", fmt_err_cnt, 16'd0);
    check("rst_ovr", ovr_cnt, 16'd0);
    check("rst_link", link_ok, 1'b0);
    check("rst_bank", bank_sel, 1'b0);
    check("rst_data", ram_data, 16'd0);

    // Bad checksum, nothing valid yet
    frame(0, 1'b0);
    check("bad_fmt", fmt_err_cnt, 16'd1);
    check("bad_good", good_cnt, 16'd0);
    check("bad_bank", bank_sel, 1'b0);
    rd(10'd1, d);  check("bad_rd1", d, 16'd0);
    rd(10'd5, d);  check("bad_rd5", d, 16'd0);
    rd(10'd78, d); check("bad_rd78", d, 16'd0);

    // Good frame 1..78, checksum 16'hF3F6, reader idle
    frame(0, 1'b1);
    check("g1_good", good_cnt, 16'd1);
    check("g1_bank", bank_sel, 1'b1);
    check("g1_link", link_ok, 1'b1);
    rd(10'd5, d);  check("g1_rd5", d, 16'd5);
    rd(10'd1, d);  check("g1_rd1", d, 16'd1);
    rd(10'd78, d); check("g1_rd78", d, 16'd78);
    rd(10'd79, d); check("g1_rd79", d, 16'd0);
    rd(10'd0, d);  check("g1_rd0", d, 16'd0);

    // sof at word 40 aborts; next full frame (101..178) is accepted
    for (int i = 1; i <= 39; i++) word(i == 1, 16'(100 + i));
    frame(100, 1'b1);
    check("ab_fmt", fmt_err_cnt, 16'd2);
    check("ab_good", good_cnt, 16'd2);
    check("ab_bank", bank_sel, 1'b0);
    rd(10'd5, d);  check("ab_rd5", d, 16'd105);
    rd(10'd78, d); check("ab_rd78", d, 16'd178);

    // Reader window: frame completes while busy, waits for window end
    start_DPRAM = 1'b1;
    tick();
    e0 = cyc;
    start_DPRAM = 1'b0;
    repeat (10) tick();
    frame(200, 1'b1);
    check("win_good", good_cnt, 16'd3);
    check("win_bank_hold", bank_sel, 1'b0);
    rd(10'd5, d);  check("win_rd_frozen", d, 16'd105);
    word(1'b1, 16'd1);
    check("win_ovr", ovr_cnt, 16'd1);
    while (cyc < e0 + 400) tick();
    check("win_bank_400", bank_sel, 1'b0);
    tick();
    check("win_bank_401", bank_sel, 1'b1);
    rd(10'd5, d);  check("win_rd5", d, 16'd205);
    check("win_ovr_keep", ovr_cnt, 16'd1);

    // Link timeout after last good frame
    frame(300, 1'b1);
    g = cyc;
    check("to_bank", bank_sel, 1'b0);
    check("to_good", good_cnt, 16'd4);
    while (cyc < g + int'(TO) - 1) tick();
    check("to_link_before", link_ok, 1'b1);
    tick();
    check("to_link_after", link_ok, 1'b0);
    rd(10'd5, d);  check("to_rd5_stale", d, 16'd305);

    // Reset mid-frame
    for (int i = 1; i <= 20; i++) word(i == 1, 16'(400 + i));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_good", good_cnt, 16'd0);
    check("mr_fmt", fmt_err_cnt, 16'd0);
    check("mr_ovr", ovr_cnt, 16'd0);
    check("mr_link", link_ok, 1'b0);
    check("mr_bank", bank_sel, 1'b0);
    check("mr_data", ram_data, 16'd0);
    for (int i = 21; i <= NW; i++) word(1'b0, 16'(400 + i));
    word(1'b0, 16'h1234);
    check("mr_tail_good", good_cnt, 16'd0);
    check("mr_tail_fmt", fmt_err_cnt, 16'd0);
    frame(500, 1'b1);
    check("mr_new_good", good_cnt, 16'd1);
    check("mr_new_bank", bank_sel, 1'b1);
    check("mr_new_link", link_ok, 1'b1);
    rd(10'd5, d);  check("mr_new_rd5", d, 16'd505);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
